mem_arbiter: RTL

//  Shares the single physical memory port (DPI pmem bridge) between instruction fetch (IFU) and

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and load/store (LSU).
// One transaction in flight at a time: IDLE arbitrates, REQ presents, WAIT collects the response.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LSU_PRIO = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ifu_req_valid,
    output logic              o_ifu_req_ready,
    input  logic [ADDR_W-1:0] i_ifu_addr,
    output logic              o_ifu_rsp_valid,
    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic              i_lsu_wen,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [7:0]        i_lsu_wmask,
    output logic              o_lsu_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [7:0]        o_mem_wmask,
    input  logic              i_mem_rsp_valid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic            TO_EN    = (TIMEOUT != 0);
    localparam logic            PRIO_LSU = (LSU_PRIO != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_owner_lsu;
    logic               r_last_lsu;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_wen;
    logic [DATA_W-1:0]  r_wdata;
    logic [7:0]         r_wmask;
    logic [CNT_W-1:0]   r_cnt;

    logic w_idle;
    logic w_wait;
    logic w_pick_lsu;
    logic w_lsu_gnt;
    logic w_ifu_gnt;
    logic w_rsp_ok;
    logic w_tmo;
    logic w_rsp;

    // A lone requester always wins; a tie goes to LSU or to whoever was not granted last.
    assign w_idle     = (r_state == ST_IDLE) & ~i_rst;
    assign w_pick_lsu = i_lsu_req_valid & (~i_ifu_req_valid | PRIO_LSU | ~r_last_lsu);
    assign w_lsu_gnt  = w_idle & w_pick_lsu;
    assign w_ifu_gnt  = w_idle & i_ifu_req_valid & ~w_pick_lsu;

    // A real response beats a timeout landing in the same cycle.
    assign w_wait   = (r_state == ST_WAIT) & ~i_rst;
    assign w_rsp_ok = w_wait & i_mem_rsp_valid;
    assign w_tmo    = w_wait & ~i_mem_rsp_valid & TO_EN & (r_cnt == TO_VAL);
    assign w_rsp    = w_rsp_ok | w_tmo;

    assign o_ifu_req_ready = w_ifu_gnt;
    assign o_lsu_req_ready = w_lsu_gnt;
    assign o_ifu_rsp_valid = w_rsp & ~r_owner_lsu;
    assign o_lsu_rsp_valid = w_rsp & r_owner_lsu;
    assign o_rsp_err       = w_tmo;
    assign o_rsp_rdata     = (w_rsp_ok & ~r_wen) ? i_mem_rdata : {DATA_W{1'b0}};
    assign o_mem_req_valid = (r_state == ST_REQ) & ~i_rst;
    assign o_mem_addr      = r_addr;
    assign o_mem_wen       = r_wen;
    assign o_mem_wdata     = r_wdata;
    assign o_mem_wmask     = r_wmask;

    // Transaction FSM: latch the winner's request, hand it to memory, wait for its response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_owner_lsu <= 1'b0;
            r_last_lsu  <= 1'b0;
            r_addr      <= {ADDR_W{1'b0}};
            r_wen       <= 1'b0;
            r_wdata     <= {DATA_W{1'b0}};
            r_wmask     <= 8'h00;
            r_cnt       <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lsu_gnt) begin
                        r_state     <= ST_REQ;
                        r_owner_lsu <= 1'b1;
                        r_last_lsu  <= 1'b1;
                        r_addr      <= i_lsu_addr;
                        r_wen       <= i_lsu_wen;
                        r_wdata     <= i_lsu_wdata;
                        r_wmask     <= i_lsu_wmask;
                    end else if (w_ifu_gnt) begin
                        r_state     <= ST_REQ;
                        r_owner_lsu <= 1'b0;
                        r_last_lsu  <= 1'b0;
                        r_addr      <= i_ifu_addr;
                        r_wen       <= 1'b0;
                        r_wdata     <= {DATA_W{1'b0}};
                        r_wmask     <= 8'h00;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (i_mem_req_ready) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (w_rsp) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
